// File: rtl/mips_core_pkg.sv
// Shared types for the multithreaded MIPS core: address width, scheduler
// state encoding and the reset-PC helper used by the thread scheduler.
package mips_core_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int DEFAULT_NUM_THREADS = 2;
    localparam int TID_W               = $clog2(DEFAULT_NUM_THREADS);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [TID_W-1:0]      tid_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        HALTED = 2'd3
    } sched_state_e;

    // Start PC of thread t, wrapping modulo 2^ADDR_WIDTH.
    function automatic addr_t init_pc(input addr_t base, input addr_t stride, input int t);
        return base + addr_t'(t) * stride;
    endfunction

endpackage

// File: rtl/rr_thread_picker.sv
// Combinational round-robin pick: first active thread after cur_id,
// wrapping at NUM_THREADS-1; cur_id itself is never selected.
module rr_thread_picker #(
    parameter int NUM_THREADS = 2,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic [TID_W-1:0]       cur_id,
    input  logic [NUM_THREADS-1:0] active_mask,
    output logic [TID_W-1:0]       next_id,
    output logic                   any_other_active
);

    // Scan from the farthest candidate down so the nearest active one wins.
    always_comb begin
        next_id          = cur_id;
        any_other_active = 1'b0;
        for (int k = NUM_THREADS - 1; k >= 1; k--) begin
            if (active_mask[cur_id + TID_W'(k)]) begin
                next_id          = cur_id + TID_W'(k);
                any_other_active = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Hardware-thread scheduler: round-robins between active threads on quantum
// expiry, yield or halt, draining the pipeline and swapping resume PCs.
module thread_scheduler
    import mips_core_pkg::*;
#(
    parameter int                    NUM_THREADS = 2,
    parameter int                    QUANTUM     = 256,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STRIDE   = 32'h0000_1000,
    localparam int                   TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_yield,
    input  logic                  i_halt,
    input  logic                  i_pipe_empty,
    input  logic [ADDR_WIDTH-1:0] i_resume_pc,
    output logic [TID_W-1:0]      o_thread_id,
    output logic                  o_fetch_hold,
    output logic                  o_load_pc_valid,
    output logic [ADDR_WIDTH-1:0] o_load_pc,
    output logic                  o_all_halted
);

    localparam int CNT_W = $clog2(QUANTUM);

    sched_state_e            state;
    logic [TID_W-1:0]        thread_id;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_THREADS-1:0]  active_mask;
    logic [ADDR_WIDTH-1:0]   pc_table [NUM_THREADS];

    logic [NUM_THREADS-1:0]  cur_onehot;
    logic [NUM_THREADS-1:0]  mask_eff;
    logic [TID_W-1:0]        next_id;
    logic                    any_other;
    logic                    trigger;
    logic                    leaving;

    assign cur_onehot = NUM_THREADS'(1) << thread_id;

    // A halt retiring this cycle already removes the thread from the pick.
    assign mask_eff = (i_halt && (state == RUN || state == DRAIN))
                    ? (active_mask & ~cur_onehot) : active_mask;

    assign trigger = (state == RUN) &&
                     (i_halt || i_yield || (cnt == CNT_W'(QUANTUM - 1)));
    assign leaving = trigger && (any_other || !mask_eff[thread_id]);

    assign o_fetch_hold = (state != RUN) || leaving;
    assign o_thread_id  = thread_id;

    rr_thread_picker #(
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_picker (
        .cur_id           (thread_id),
        .active_mask      (mask_eff),
        .next_id          (next_id),
        .any_other_active (any_other)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            thread_id       <= '0;
            cnt             <= '0;
            active_mask     <= '1;
            o_load_pc_valid <= 1'b0;
            o_load_pc       <= RESET_PC;
            o_all_halted    <= 1'b0;
            for (int t = 0; t < NUM_THREADS; t++)
                pc_table[t] <= init_pc(RESET_PC, PC_STRIDE, t);
        end else begin
            o_load_pc_valid <= 1'b0;
            case (state)
                RUN: begin
                    active_mask <= mask_eff;
                    if (trigger) begin
                        if (any_other) begin
                            state <= DRAIN;
                        end else if (mask_eff[thread_id]) begin
                            cnt <= '0;
                        end else begin
                            state        <= HALTED;
                            o_all_halted <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    active_mask <= mask_eff;
                    if (mask_eff == '0) begin
                        state        <= HALTED;
                        o_all_halted <= 1'b1;
                    end else if (i_pipe_empty) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    // Read of pc_table[next_id] sees the pre-write contents.
                    if (active_mask[thread_id])
                        pc_table[thread_id] <= i_resume_pc;
                    o_load_pc       <= pc_table[next_id];
                    o_load_pc_valid <= 1'b1;
                    thread_id       <= next_id;
                    cnt             <= '0;
                    state           <= RUN;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench: a 2-thread/quantum-8 instance for quantum, drain, halt and
// reset behaviour, plus a 4-thread instance for wrap-around and drain halts.
module tb_thread_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 2-thread instance
    logic        yield_a, halt_a, empty_a;
    logic [31:0] resume_a;
    logic        tid_a;
    logic        hold_a, lpv_a, ah_a;
    logic [31:0] lpc_a;

    thread_scheduler #(
        .NUM_THREADS (2),
        .QUANTUM     (8),
        .RESET_PC    (32'h0),
        .PC_STRIDE   (32'h0000_1000)
    ) dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_yield         (yield_a),
        .i_halt          (halt_a),
        .i_pipe_empty    (empty_a),
        .i_resume_pc     (resume_a),
        .o_thread_id     (tid_a),
        .o_fetch_hold    (hold_a),
        .o_load_pc_valid (lpv_a),
        .o_load_pc       (lpc_a),
        .o_all_halted    (ah_a)
    );

    // 4-thread instance
    logic        yield_b, halt_b, empty_b;
    logic [31:0] resume_b;
    logic [1:0]  tid_b;
    logic        hold_b, lpv_b, ah_b;
    logic [31:0] lpc_b;

    thread_scheduler #(
        .NUM_THREADS (4),
        .QUANTUM     (64),
        .RESET_PC    (32'h0),
        .PC_STRIDE   (32'h0000_1000)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_yield         (yield_b),
        .i_halt          (halt_b),
        .i_pipe_empty    (empty_b),
        .i_resume_pc     (resume_b),
        .o_thread_id     (tid_b),
        .o_fetch_hold    (hold_b),
        .o_load_pc_valid (lpv_b),
        .o_load_pc       (lpc_b),
        .o_all_halted    (ah_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One switch on the 4-thread instance with the pipe already empty.
    task automatic sw_b(input bit use_halt, input logic [31:0] exp_tid, input logic [31:0] exp_pc);
        resume_b = 32'hC000_0000 | 32'(tid_b);
        if (use_halt) halt_b = 1'b1; else yield_b = 1'b1;
        #1;
        chk("b_trig_hold", 32'(hold_b), 32'd1);
        tick();
        halt_b  = 1'b0;
        yield_b = 1'b0;
        tick();
        tick();
        chk("b_tid", 32'(tid_b), exp_tid);
        chk("b_lpv", 32'(lpv_b), 32'd1);
        chk("b_lpc", lpc_b, exp_pc);
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0;
        yield_a = 0; halt_a = 0; empty_a = 1; resume_a = 32'h0;
        yield_b = 0; halt_b = 0; empty_b = 1; resume_b = 32'h0;
        #2;
        chk("rst_tid",  32'(tid_a),  32'd0);
        chk("rst_hold", 32'(hold_a), 32'd0);
        chk("rst_lpv",  32'(lpv_a),  32'd0);
        chk("rst_lpc",  lpc_a,       32'h0);
        chk("rst_ah",   32'(ah_a),   32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Quantum: expiry after 8 RUN cycles, 3-cycle switch latency
        repeat (6) tick();
        chk("q_pre_hold", 32'(hold_a), 32'd0);
        tick();
        chk("q_trig_hold", 32'(hold_a), 32'd1);
        chk("q_trig_tid",  32'(tid_a),  32'd0);
        resume_a = 32'h40;
        tick();
        chk("q_drain_hold", 32'(hold_a), 32'd1);
        chk("q_drain_lpv",  32'(lpv_a),  32'd0);
        tick();
        chk("q_switch_tid", 32'(tid_a), 32'd0);
        tick();
        chk("q_tid1",  32'(tid_a),  32'd1);
        chk("q_lpv1",  32'(lpv_a),  32'd1);
        chk("q_lpc1",  lpc_a,       32'h1000);
        chk("q_hold1", 32'(hold_a), 32'd0);
        tick();
        chk("q_lpv_pulse", 32'(lpv_a), 32'd0);
        repeat (5) tick();
        chk("q2_pre_hold", 32'(hold_a), 32'd0);
        tick();
        chk("q2_trig_hold", 32'(hold_a), 32'd1);
        resume_a = 32'h1234;
        repeat (3) tick();
        chk("q_tid0", 32'(tid_a), 32'd0);
        chk("q_lpv0", 32'(lpv_a), 32'd1);
        chk("q_lpc0", lpc_a,      32'h40);

        // Drain: yield with a busy pipe for 5 cycles
        tick();
        resume_a = 32'h88; empty_a = 0; yield_a = 1;
        #1;
        chk("d_trig_hold", 32'(hold_a), 32'd1);
        tick();
        yield_a = 0;
        for (int i = 0; i < 5; i++) begin
            chk("d_hold", 32'(hold_a), 32'd1);
            chk("d_tid",  32'(tid_a),  32'd0);
            chk("d_lpv",  32'(lpv_a),  32'd0);
            if (i < 4) tick();
        end
        empty_a = 1;
        tick();
        chk("d_switch_hold", 32'(hold_a), 32'd1);
        chk("d_switch_tid",  32'(tid_a),  32'd0);
        tick();
        chk("d_tid1", 32'(tid_a), 32'd1);
        chk("d_lpv1", 32'(lpv_a), 32'd1);
        chk("d_lpc1", lpc_a,      32'h1234);

        // Back to thread 0, then halt coinciding with quantum expiry
        tick();
        yield_a = 1; resume_a = 32'h2000;
        tick();
        yield_a = 0;
        tick();
        tick();
        chk("h_tid0", 32'(tid_a), 32'd0);
        chk("h_lpc0", lpc_a,      32'h88);
        repeat (7) tick();
        halt_a = 1;
        #1;
        chk("h_trig_hold", 32'(hold_a), 32'd1);
        tick();
        halt_a = 0;
        chk("h_drain_hold", 32'(hold_a), 32'd1);
        tick();
        tick();
        chk("h_tid1", 32'(tid_a), 32'd1);
        chk("h_lpv1", 32'(lpv_a), 32'd1);
        chk("h_lpc1", lpc_a,      32'h2000);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lpv_a) pulses++;
        end
        chk("h_solo_pulses", 32'(pulses), 32'd0);
        chk("h_solo_tid",    32'(tid_a),  32'd1);
        yield_a = 1;
        tick();
        yield_a = 0;
        tick();
        chk("h_solo_yield_lpv", 32'(lpv_a), 32'd0);
        chk("h_solo_yield_tid", 32'(tid_a), 32'd1);
        halt_a = 1;
        #1;
        chk("h_last_hold", 32'(hold_a), 32'd1);
        tick();
        halt_a = 0;
        chk("h_all_halted", 32'(ah_a),   32'd1);
        chk("h_halt_hold",  32'(hold_a), 32'd1);
        yield_a = 1;
        tick();
        yield_a = 0;
        repeat (12) tick();
        chk("h_still_halted", 32'(ah_a),   32'd1);
        chk("h_still_hold",   32'(hold_a), 32'd1);
        chk("h_still_lpv",    32'(lpv_a),  32'd0);

        // Reset out of HALTED, then reset mid-DRAIN
        rst_n = 0;
        #1;
        chk("r_ah_clear", 32'(ah_a), 32'd0);
        @(posedge clk); #1; rst_n = 1;
        repeat (7) tick();
        chk("r_q_hold", 32'(hold_a), 32'd1);
        repeat (3) tick();
        chk("r_tid1", 32'(tid_a), 32'd1);
        chk("r_lpv1", 32'(lpv_a), 32'd1);
        chk("r_lpc1_reinit", lpc_a, 32'h1000);
        tick();
        empty_a = 0; yield_a = 1;
        tick();
        yield_a = 0;
        tick();
        #2 rst_n = 0;
        #1;
        chk("r_async_tid",  32'(tid_a),  32'd0);
        chk("r_async_hold", 32'(hold_a), 32'd0);
        chk("r_async_lpv",  32'(lpv_a),  32'd0);
        chk("r_async_lpc",  lpc_a,       32'h0);
        chk("r_async_ah",   32'(ah_a),   32'd0);
        @(posedge clk); #1; rst_n = 1; empty_a = 1;
        repeat (6) tick();
        chk("r_full_q_pre", 32'(hold_a), 32'd0);
        tick();
        chk("r_full_q_trig", 32'(hold_a), 32'd1);
        chk("r_full_q_tid",  32'(tid_a),  32'd0);
        repeat (3) tick();
        chk("r_next_tid", 32'(tid_a), 32'd1);
        chk("r_next_lpc", lpc_a,      32'h1000);

        // 4 threads: wrap-around with thread 2 halted
        rst_n = 0;
        #1;
        @(posedge clk); #1; rst_n = 1;
        chk("b_rst_tid", 32'(tid_b), 32'd0);
        sw_b(1'b0, 32'd1, 32'h1000);
        sw_b(1'b0, 32'd2, 32'h2000);
        sw_b(1'b1, 32'd3, 32'h3000);
        sw_b(1'b0, 32'd0, 32'hC000_0000);
        sw_b(1'b0, 32'd1, 32'hC000_0001);
        sw_b(1'b0, 32'd3, 32'hC000_0003);
        sw_b(1'b0, 32'd0, 32'hC000_0000);

        // Halt retiring during DRAIN removes thread 0 from the rotation
        empty_b = 0; yield_b = 1;
        #1;
        chk("bd_trig_hold", 32'(hold_b), 32'd1);
        tick();
        yield_b = 0; halt_b = 1;
        tick();
        halt_b = 0;
        chk("bd_hold", 32'(hold_b), 32'd1);
        chk("bd_tid",  32'(tid_b),  32'd0);
        empty_b = 1;
        tick();
        tick();
        chk("bd_tid1", 32'(tid_b), 32'd1);
        chk("bd_lpc1", lpc_b,      32'hC000_0001);
        sw_b(1'b0, 32'd3, 32'hC000_0003);
        sw_b(1'b0, 32'd1, 32'hC000_0001);
        sw_b(1'b1, 32'd3, 32'hC000_0003);
        halt_b = 1;
        tick();
        halt_b = 0;
        chk("b_all_halted", 32'(ah_b),   32'd1);
        chk("b_halt_hold",  32'(hold_b), 32'd1);
        tick();
        tick();
        chk("b_halt_lpv", 32'(lpv_b), 32'd0);
        chk("b_halt_tid", 32'(tid_b), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
